// File: rtl/dma_burst_sched_pkg.sv
// Shared types and defaults for the DMA burst scheduler.
// The optional watchdog is enabled by defining DMA_BSCH_TIMEOUT_EN.
package dma_burst_sched_pkg;

  localparam int unsigned BSCH_MAX_BURST = 16;
  localparam int unsigned BSCH_BOUNDARY  = 1024;
  localparam int unsigned BSCH_WORDS_W   = 16;
  localparam int unsigned BSCH_TIMEOUT   = 255;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned CNT_W          = 5;
  localparam int unsigned BUF_W          = 8;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_ISSUE,
    ST_XFER,
    ST_FIN
  } bsch_state_e;

endpackage

// File: rtl/dma_burst_sched_len_calc.sv
// Burst length: min(remaining words, MAX_BURST, words left before the next BOUNDARY line).
module dma_burst_sched_len_calc
  import dma_burst_sched_pkg::*;
#(
  parameter int unsigned MAX_BURST = BSCH_MAX_BURST,
  parameter int unsigned BOUNDARY  = BSCH_BOUNDARY,
  parameter int unsigned WORDS_W   = BSCH_WORDS_W,
  parameter int unsigned OFF_W     = $clog2(BOUNDARY)
) (
  input  logic [WORDS_W-1:0] rem_i,
  input  logic [OFF_W-1:0]   addr_off_i,
  output logic [CNT_W-1:0]   len_o
);

  logic [31:0]      room_w;
  logic [CNT_W-1:0] rem_c;
  logic [CNT_W-1:0] room_c;

  always_comb begin
    room_w = (32'(BOUNDARY) - 32'(addr_off_i)) >> 2;
    rem_c  = (32'(rem_i) < 32'(MAX_BURST)) ? CNT_W'(rem_i) : CNT_W'(MAX_BURST);
    room_c = (room_w < 32'(MAX_BURST)) ? CNT_W'(room_w) : CNT_W'(MAX_BURST);
    len_o  = (rem_c < room_c) ? rem_c : room_c;
  end

endmodule

// File: rtl/dma_burst_sched.sv
// DMA command sequencer: splits a transfer request into boundary-safe INCR bursts.
// Define DMA_BSCH_TIMEOUT_EN to add a beat watchdog that aborts a stalled request.
module dma_burst_sched
  import dma_burst_sched_pkg::*;
#(
  parameter int unsigned MAX_BURST = BSCH_MAX_BURST,
  parameter int unsigned BOUNDARY  = BSCH_BOUNDARY,
  parameter int unsigned WORDS_W   = BSCH_WORDS_W,
  parameter int unsigned TIMEOUT   = BSCH_TIMEOUT
) (
  input  logic               I_BSCH_HCLK,
  input  logic               I_BSCH_RESET,
  input  logic               I_BSCH_REQ,
  input  logic [31:0]        I_BSCH_ADDR,
  input  logic [WORDS_W-1:0] I_BSCH_WORDS,
  input  logic               I_BSCH_WRITE,
  input  logic               I_BSCH_ABORT,
  input  logic               I_BSCH_DMA_READY,
  input  logic               I_BSCH_BEAT,
  output logic               O_BSCH_BUSY,
  output logic               O_BSCH_DONE,
  output logic               O_BSCH_ERR,
  output logic               O_BSCH_DMA_START,
  output logic [31:0]        O_BSCH_DMA_ADDR,
  output logic [4:0]         O_BSCH_DMA_COUNT,
  output logic [2:0]         O_BSCH_DMA_SIZE,
  output logic               O_BSCH_DMA_WRITE,
  output logic               O_BSCH_DMA_STOP,
  output logic [7:0]         O_BSCH_BUF_ADDR
);

  localparam int unsigned OFF_W = $clog2(BOUNDARY);

  bsch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WORDS_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   beat_q, beat_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [ADDR_W-1:0]  dma_addr_q, dma_addr_d;
  logic [CNT_W-1:0]   dma_count_q, dma_count_d;
  logic               write_q, write_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               start_q, start_d;
  logic               stop_q, stop_d;

  logic [CNT_W-1:0]   len_c;
  logic               active_c;
  logic               beat_ok_c;
  logic               burst_done_c;
  logic               abort_c;

`ifdef DMA_BSCH_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_c;
`endif

  dma_burst_sched_len_calc #(
    .MAX_BURST (MAX_BURST),
    .BOUNDARY  (BOUNDARY),
    .WORDS_W   (WORDS_W),
    .OFF_W     (OFF_W)
  ) u_len_calc (
    .rem_i      (rem_q),
    .addr_off_i (addr_q[OFF_W-1:0]),
    .len_o      (len_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    len_d       = len_q;
    beat_d      = beat_q;
    buf_d       = buf_q;
    dma_addr_d  = dma_addr_q;
    dma_count_d = dma_count_q;
    write_d     = write_q;
    err_d       = err_q;
    stop_d      = 1'b0;

    active_c     = (state_q == ST_ISSUE) || (state_q == ST_XFER);
    beat_ok_c    = active_c && I_BSCH_BEAT;
    burst_done_c = beat_ok_c && (CNT_W'(beat_q + CNT_W'(1)) == len_q) &&
                   ((state_q == ST_XFER) || I_BSCH_DMA_READY);
    abort_c      = I_BSCH_ABORT && (active_c || (state_q == ST_CALC));

`ifdef DMA_BSCH_TIMEOUT_EN
    wd_d      = '0;
    timeout_c = 1'b0;
    if (active_c && !I_BSCH_BEAT && !I_BSCH_DMA_READY) begin
      wd_d      = WD_W'(wd_q + WD_W'(1));
      timeout_c = (32'(wd_q) == (TIMEOUT - 1));
    end
    abort_c = abort_c || timeout_c;
`endif

    case (state_q)
      ST_IDLE: begin
        if (I_BSCH_REQ) begin
          addr_d  = I_BSCH_ADDR;
          rem_d   = I_BSCH_WORDS;
          write_d = I_BSCH_WRITE;
          buf_d   = '0;
          err_d   = 1'b0;
          if (I_BSCH_ADDR[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = ST_FIN;
          end else if (I_BSCH_WORDS == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        len_d       = len_c;
        beat_d      = '0;
        dma_addr_d  = addr_q;
        dma_count_d = len_c;
        state_d     = (rem_q == '0) ? ST_FIN : ST_ISSUE;
      end
      ST_ISSUE, ST_XFER: begin
        if (beat_ok_c) begin
          beat_d = CNT_W'(beat_q + CNT_W'(1));
          buf_d  = BUF_W'(buf_q + BUF_W'(1));
        end
        if (burst_done_c) begin
          addr_d  = addr_q + {{(ADDR_W-CNT_W-2){1'b0}}, len_q, 2'b00};
          rem_d   = WORDS_W'(rem_q - WORDS_W'(len_q));
          state_d = ST_CALC;
        end else if ((state_q == ST_ISSUE) && I_BSCH_DMA_READY) begin
          state_d = ST_XFER;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides any same-cycle beat or burst completion
    if (abort_c) begin
      state_d = ST_FIN;
      addr_d  = addr_q;
      rem_d   = rem_q;
      beat_d  = beat_q;
      buf_d   = buf_q;
      err_d   = 1'b1;
      stop_d  = 1'b1;
    end

    busy_d  = (state_d == ST_CALC) || (state_d == ST_ISSUE) || (state_d == ST_XFER);
    done_d  = (state_d == ST_FIN);
    start_d = (state_d == ST_ISSUE);
  end

  always_ff @(posedge I_BSCH_HCLK or posedge I_BSCH_RESET) begin
    if (I_BSCH_RESET) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      buf_q       <= '0;
      dma_addr_q  <= '0;
      dma_count_q <= '0;
      write_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      buf_q       <= buf_d;
      dma_addr_q  <= dma_addr_d;
      dma_count_q <= dma_count_d;
      write_q     <= write_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
    end
  end

`ifdef DMA_BSCH_TIMEOUT_EN
  always_ff @(posedge I_BSCH_HCLK or posedge I_BSCH_RESET) begin
    if (I_BSCH_RESET) wd_q <= '0;
    else              wd_q <= wd_d;
  end
`endif

  assign O_BSCH_BUSY      = busy_q;
  assign O_BSCH_DONE      = done_q;
  assign O_BSCH_ERR       = err_q;
  assign O_BSCH_DMA_START = start_q;
  assign O_BSCH_DMA_ADDR  = dma_addr_q;
  assign O_BSCH_DMA_COUNT = dma_count_q;
  assign O_BSCH_DMA_SIZE  = HSIZE_WORD;
  assign O_BSCH_DMA_WRITE = write_q;
  assign O_BSCH_DMA_STOP  = stop_q;
  assign O_BSCH_BUF_ADDR  = buf_q;

endmodule

// File: tb/tb_dma_burst_sched.sv
// Randomized bench for dma_burst_sched: acts as the DMA engine and checks bursts
// against a burst list computed arithmetically from base address and word count.
module tb_dma_burst_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, wr, abort, ready, beat;
  logic [31:0] addr;
  logic [15:0] words;
  logic        busy, done, err, start, dma_write, stop;
  logic [31:0] dma_addr;
  logic [4:0]  dma_count;
  logic [2:0]  dma_size;
  logic [7:0]  buf_addr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dma_burst_sched dut (
    .I_BSCH_HCLK      (clk),
    .I_BSCH_RESET     (rst),
    .I_BSCH_REQ       (req),
    .I_BSCH_ADDR      (addr),
    .I_BSCH_WORDS     (words),
    .I_BSCH_WRITE     (wr),
    .I_BSCH_ABORT     (abort),
    .I_BSCH_DMA_READY (ready),
    .I_BSCH_BEAT      (beat),
    .O_BSCH_BUSY      (busy),
    .O_BSCH_DONE      (done),
    .O_BSCH_ERR       (err),
    .O_BSCH_DMA_START (start),
    .O_BSCH_DMA_ADDR  (dma_addr),
    .O_BSCH_DMA_COUNT (dma_count),
    .O_BSCH_DMA_SIZE  (dma_size),
    .O_BSCH_DMA_WRITE (dma_write),
    .O_BSCH_DMA_STOP  (stop),
    .O_BSCH_BUF_ADDR  (buf_addr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!start && n < 20) begin step(); n++; end
    chk("start_seen", 32'(start), 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin step(); n++; end
    chk("done_seen", 32'(done), 1);
  endtask

  // Full request: reference bursts, DMA handshake with random gaps, completion checks
  task automatic run_req(input logic [31:0] a, input int w, input logic wr_i);
    logic [31:0] qa[$];
    int          ql[$];
    logic [31:0] ca;
    int          cr, room, l, left, total;
    ca = a;
    cr = w;
    while (cr > 0) begin
      room = int'((32'd1024 - (ca & 32'h3FF)) >> 2);
      l = (cr < 16) ? cr : 16;
      if (room < l) l = room;
      qa.push_back(ca);
      ql.push_back(l);
      ca = ca + 32'(4 * l);
      cr = cr - l;
    end
    req = 1'b1; addr = a; words = 16'(w); wr = wr_i;
    step();
    req = 1'b0;
    chk("req_err_clr", 32'(err), 0);
    chk("req_busy", 32'(busy), 1);
    total = 0;
    foreach (qa[i]) begin
      wait_start();
      chk("dma_addr", dma_addr, qa[i]);
      chk("dma_count", 32'(dma_count), 32'(ql[i]));
      chk("dma_write", 32'(dma_write), 32'(wr_i));
      repeat ($urandom_range(0, 2)) step();
      chk("start_hold", 32'(start), 1);
      left = ql[i];
      ready = 1'b1;
      beat = 1'($urandom_range(0, 1));
      step();
      if (beat) left--;
      ready = 1'b0;
      chk("start_drop", 32'(start), 0);
      while (left > 0) begin
        beat = ($urandom_range(0, 3) != 0);
        step();
        if (beat) left--;
      end
      beat = 1'b0;
      total += ql[i];
      chk("buf_burst", 32'(buf_addr), 32'(total % 256));
    end
    wait_done();
    chk("done_err", 32'(err), 0);
    chk("done_busy", 32'(busy), 0);
    chk("done_buf", 32'(buf_addr), 32'(w % 256));
    step();
    chk("done_pulse", 32'(done), 0);
  endtask

  initial begin
    logic [31:0] ra;
    int          rw;
    rst = 1'b1; req = 1'b0; wr = 1'b0; abort = 1'b0; ready = 1'b0; beat = 1'b0;
    addr = '0; words = '0;
    repeat (3) step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_size", 32'(dma_size), 32'h2);
    chk("rst_buf", 32'(buf_addr), 0);
    rst = 1'b0;
    step();

    run_req(32'h1000, 40, 1'b0);
    run_req(32'h13F8, 10, 1'b1);
    run_req(32'hFFFF_FFF0, 10, 1'b0);

    // Zero-word and misaligned requests complete without a burst
    req = 1'b1; addr = 32'h2000; words = 16'd0;
    step();
    req = 1'b0;
    chk("w0_done", 32'(done), 1);
    chk("w0_err", 32'(err), 0);
    chk("w0_start", 32'(start), 0);
    step();
    chk("w0_start2", 32'(start), 0);
    req = 1'b1; addr = 32'h1002; words = 16'd8;
    step();
    req = 1'b0;
    chk("mis_done", 32'(done), 1);
    chk("mis_err", 32'(err), 1);
    chk("mis_start", 32'(start), 0);
    step();

    // Abort after 5 beats of a 16-beat burst
    req = 1'b1; addr = 32'h2000; words = 16'd16;
    step();
    req = 1'b0;
    wait_start();
    ready = 1'b1; beat = 1'b1;
    step();
    ready = 1'b0;
    repeat (4) step();
    beat = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_stop", 32'(stop), 1);
    chk("abort_done", 32'(done), 1);
    chk("abort_err", 32'(err), 1);
    chk("abort_busy", 32'(busy), 0);
    beat = 1'b1;
    repeat (2) step();
    beat = 1'b0;
    chk("abort_stop1", 32'(stop), 0);
    chk("abort_buf", 32'(buf_addr), 5);
    chk("abort_sticky", 32'(err), 1);
    run_req(32'h2100, 3, 1'b1);

    // Stalled burst: watchdog abort when enabled, otherwise wait forever
    req = 1'b1; addr = 32'h3000; words = 16'd8;
    step();
    req = 1'b0;
    wait_start();
    ready = 1'b1;
    step();
    ready = 1'b0;
`ifdef DMA_BSCH_TIMEOUT_EN
    begin
      int n = 0;
      while (!done && n < 300) begin step(); n++; end
      chk("wd_done", 32'(done), 1);
      chk("wd_err", 32'(err), 1);
    end
`else
    repeat (300) step();
    chk("stall_busy", 32'(busy), 1);
    chk("stall_done", 32'(done), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("stall_abort", 32'(done), 1);
`endif
    step();

    // Reset in the middle of a burst
    req = 1'b1; addr = 32'h1000; words = 16'd40;
    step();
    req = 1'b0;
    wait_start();
    ready = 1'b1; beat = 1'b1;
    step();
    ready = 1'b0;
    repeat (2) step();
    beat = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_start", 32'(start), 0);
    chk("mrst_buf", 32'(buf_addr), 0);
    chk("mrst_addr", dma_addr, 0);
    chk("mrst_count", 32'(dma_count), 0);
    chk("mrst_size", 32'(dma_size), 32'h2);
    step();
    rst = 1'b0;
    step();
    run_req(32'h0, 300, 1'b0);

    // Random requests, biased towards boundary-adjacent addresses
    for (int t = 0; t < 8; t++) begin
      ra = $urandom;
      if (ra[0]) ra = (ra & 32'hFFFF_FC00) | (32'($urandom_range(200, 255)) << 2);
      else       ra = ra & 32'hFFFF_FFFC;
      rw = $urandom_range(1, 70);
      run_req(ra, rw, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
